// File: rtl/mem_rmw_ctrl_pkg.sv
// Shared access-size codes, RMW state encodings and lane-merge helper for the data-memory responder.
package mem_rmw_ctrl_pkg;

  localparam logic [1:0] EXT_M_8BIT  = 2'b00;
  localparam logic [1:0] EXT_M_16BIT = 2'b01;
  localparam logic [1:0] EXT_M_32BIT = 2'b10;

  typedef enum logic [1:0] {
    RMW_IDLE = 2'b00,
    RMW_RD   = 2'b01,
    RMW_WR   = 2'b10,
    RMW_LD   = 2'b11
  } rmw_state_e;

  function automatic logic is_word(input logic [1:0] funct);
    return (funct != EXT_M_8BIT) && (funct != EXT_M_16BIT);
  endfunction

  // Lane i comes from new_w when be[i] is set, otherwise from old_w.
  function automatic logic [31:0] merge_lanes(input logic [3:0]  be,
                                              input logic [31:0] new_w,
                                              input logic [31:0] old_w);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_be_gen.sv
// Byte-enable decode from access size and byte lane; misaligned halfwords select the upper half.
module mem_be_gen
  import mem_rmw_ctrl_pkg::*;
(
  input  logic [1:0] funct_i,
  input  logic [1:0] a1_a0_i,
  output logic [3:0] be_o
);

  always_comb begin
    be_o = 4'b1111;
    case (funct_i)
      EXT_M_8BIT:  be_o = 4'b0001 << a1_a0_i;
      EXT_M_16BIT: be_o = (a1_a0_i == 2'b00) ? 4'b0011 : 4'b1100;
      default:     be_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Read-modify-write data-memory responder in front of a word-only synchronous SRAM.
// Word stores take 1 cycle, sub-word stores and loads 2; Busy_O stalls the CPU meanwhile.
module mem_rmw_ctrl
  import mem_rmw_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              Clk_I,
  input  logic              Rst_I,
  input  logic              Req_I,
  input  logic              We_I,
  input  logic [1:0]        Funct_I,
  input  logic [31:0]       Addr_I,
  input  logic [31:0]       Wdata_I,
  output logic [31:0]       Rdata_O,
  output logic              Ack_O,
  output logic              Busy_O,
  output logic [ADDR_W-1:0] SramAddr_O,
  output logic              SramWe_O,
  output logic [31:0]       SramWdata_O,
  input  logic [31:0]       SramRdata_I
);

  rmw_state_e        state_q;
  logic              we_q;
  logic [1:0]        funct_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_d;
  logic [3:0]        be;

  // Address bits above the SRAM word index alias, so they are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^Addr_I[31:ADDR_W+2];

  mem_be_gen u_be_gen (
    .funct_i (funct_q),
    .a1_a0_i (lane_q),
    .be_o    (be)
  );

  assign rdata_d = (state_q == RMW_LD) ? SramRdata_I : rdata_q;

  always_ff @(posedge Clk_I or posedge Rst_I) begin
    if (Rst_I) begin
      state_q <= RMW_IDLE;
      we_q    <= 1'b0;
      funct_q <= 2'b00;
      waddr_q <= '0;
      lane_q  <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        RMW_IDLE: begin
          if (Req_I) begin
            we_q    <= We_I;
            funct_q <= Funct_I;
            waddr_q <= Addr_I[ADDR_W+1:2];
            lane_q  <= Addr_I[1:0];
            wdata_q <= Wdata_I;
            state_q <= (We_I && is_word(Funct_I)) ? RMW_WR : RMW_RD;
          end
        end
        RMW_RD:  state_q <= we_q ? RMW_WR : RMW_LD;
        RMW_WR:  state_q <= RMW_IDLE;
        RMW_LD: begin
          rdata_q <= rdata_d;
          state_q <= RMW_IDLE;
        end
        default: state_q <= RMW_IDLE;
      endcase
    end
  end

  assign Busy_O      = (state_q != RMW_IDLE);
  assign Ack_O       = (state_q == RMW_WR) || (state_q == RMW_LD);
  assign SramWe_O    = (state_q == RMW_WR);
  assign SramAddr_O  = waddr_q;
  assign SramWdata_O = (state_q == RMW_WR) ? merge_lanes(be, wdata_q, SramRdata_I) : 32'h0;
  assign Rdata_O     = rdata_d;

endmodule

// File: doc/mem_rmw_ctrl.md
Name: mem_rmw_ctrl

Overview:
- Data-memory responder that sits between the CPU memory stage and a word-only synchronous SRAM.
- The CPU supplies store data already placed in its byte lanes, as the existing store-alignment logic produces. This block merges that data into the addressed word with a read-modify-write sequence; sub-word loads use the same read path.
- For loads it returns the raw addressed word; downstream load-extraction logic selects and zero-extends the lane.
- Busy_O stalls the pipeline while a sequence is in flight.

Parameters:
- ADDR_W, 10, word-address width of the SRAM (SRAM depth = 2^ADDR_W words).

Ports:
- Clk_I  in  1  single clock; all state updates on its rising edge.
- Rst_I  in  1  reset, asynchronous, active-high.
- Req_I  in  1  access request; sampled only in IDLE.
- We_I  in  1  1 = store, 0 = load.
- Funct_I  in  2  access size: `EXT_M_8BIT, `EXT_M_16BIT, any other value = word.
- Addr_I  in  32  byte address; [ADDR_W+1:2] selects the word, [1:0] selects the lane.
- Wdata_I  in  32  lane-positioned store data.
- Rdata_O  out  32  raw SRAM word for loads.
- Ack_O  out  1  one-cycle completion pulse.
- Busy_O  out  1  high in every state except IDLE.
- SramAddr_O  out  ADDR_W  SRAM word address.
- SramWe_O  out  1  SRAM write enable.
- SramWdata_O  out  32  SRAM write data.
- SramRdata_I  in  32  SRAM read data, valid one cycle after its address is presented.

Behaviour:
- Reset (async, Rst_I=1):
  - FSM goes to IDLE; latched request registers and Rdata_O clear to 0.
  - Ack_O=0, Busy_O=0, SramWe_O=0, SramAddr_O=0, SramWdata_O=0.
  - Reset during RD or WR aborts the access; no SRAM write occurs after Rst_I rises.
- Accept: in IDLE with Req_I=1, latch We_I, Funct_I, Addr_I and Wdata_I at the clock edge. Req_I is ignored in all other states; the CPU holds Req_I while Busy_O=1.
- States: IDLE, RD, WR, LD.
- Transitions:
  - IDLE & Req & We & word -> WR.
  - IDLE & Req & We & sub-word -> RD.
  - IDLE & Req & !We -> RD.
  - RD -> WR if the latched request is a store, else LD.
  - WR -> IDLE.
  - LD -> IDLE.
- Byte enables BE[3:0], derived from the latched Funct and A1_A0:
  - 8-bit: 4'b0001 << A1_A0.
  - 16-bit: 4'b0011 if A1_A0==00, else 4'b1100; misaligned halfwords go to the upper half, matching store placement.
  - word: 4'b1111; A1_A0 is ignored.
- RD: SramAddr_O = latched word address, SramWe_O=0.
- WR:
  - SramAddr_O = latched word address, SramWe_O=1.
  - SramWdata_O byte lane i = latched Wdata lane i if BE[i], else SramRdata_I lane i.
  - Word stores take all lanes from Wdata, so no read is needed.
  - Ack_O=1.
- LD: Rdata_O follows SramRdata_I combinationally and is registered at the end of LD; Rdata_O holds its last value outside LD. Ack_O=1.
- Latency, counted from the accept edge to the Ack_O cycle:
  - word store: 1 cycle.
  - sub-word store: 2 cycles.
  - load: 2 cycles.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately following Ack_O, so there is no dead cycle beyond IDLE itself.
- Address wrap: bits above ADDR_W+1 are ignored, so the address aliases modulo the SRAM size.
- Ack_O, Busy_O and SramWe_O are decoded from the state register only; they have no combinational path from Req_I.

Decomposition:
- Shared header: reuse `EXT_M_8BIT and `EXT_M_16BIT from the instruction header. Add state encodings `RMW_IDLE/`RMW_RD/`RMW_WR/`RMW_LD (2 bits) to the same header.
- One combinational sub-module, mem_be_gen(Funct, A1_A0 -> BE[3:0]), shared with any future byte-enable SRAM port.

Test Plan:
- Word store: preload word 5 = 32'hFFFF_FFFF; Req=1, We=1, Funct=word, Addr=32'h14, Wdata=32'h1234_5678 -> SramWe_O=1 in the cycle after accept, word 5 = 32'h1234_5678, Ack_O pulses once, Busy_O high 1 cycle.
- Byte store: word 5 = 32'hAABB_CCDD; Funct=`EXT_M_8BIT, Addr=32'h16, Wdata=32'h0077_0000 -> RD then WR; word 5 = 32'hAA77_CCDD; Ack_O 2 cycles after accept.
- Halfword store, misaligned: word 5 = 32'hAABB_CCDD; Funct=`EXT_M_16BIT, Addr=32'h15, Wdata=32'h9988_0000 -> word 5 = 32'h9988_CCDD.
- Load then store back-to-back: load Addr=32'h14 -> Rdata_O = 32'h9988_CCDD with Ack_O; the next request, accepted in the following IDLE cycle, completes correctly; Req_I toggling while Busy_O=1 causes no extra access.
- Reset mid-operation: assert Rst_I during RD of a byte store -> SramWe_O=0 immediately, no write occurs, word unchanged, outputs at their reset values, FSM in IDLE after release.
- Exhaustive byte enables: every Funct × A1_A0 combination, starting from word 32'h0000_0000 with Wdata = 32'hFFFF_FFFF -> stored word has exactly the BE lanes set to FF.
